fsm_seq_driver: RTL and testbench
=================================

FSM_SEQ_DRIVER -- requirements
Module: fsm_seq_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles spent in WAIT before flagging an error (range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to run one sequence; sampled only in IDLE or ERR.
REQ-005 SHALL have port order, input, 1: 0 = C1 first then C2, 1 = C2 first then C1; latched when start is accepted.
REQ-006 SHALL have port gap, input, 4: number of idle cycles inserted after the first condition pulse and after the I pulse; latched when start is accepted.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of a running sequence.
REQ-008 SHALL have port ca_in, input, 2: status code returned by the interlock FSM under drive.
REQ-009 SHALL have port c1, output, 1: condition-1 pulse to the interlock FSM.
REQ-010 SHALL have port c2, output, 1: condition-2 pulse to the interlock FSM.
REQ-011 SHALL have port i, output, 1: enable pulse to the interlock FSM.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE and ERR.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-014 SHALL have port error, output, 1: high while in ERR.

Function
REQ-015 SHALL implement the states IDLE, FIRST, GAP1, IND, GAP2, SECOND, WAIT, DONE and ERR, with all outputs decoded from the state register only (Moore).
REQ-016 SHALL go from IDLE to FIRST when start=1, latching order and gap on that edge.
REQ-017 SHALL go from ERR to FIRST when start=1, latching order and gap; otherwise it SHALL remain in ERR.
REQ-018 SHALL hold FIRST for exactly 1 cycle, driving c1 when order=0 or c2 when order=1; all other pulse outputs low.
REQ-019 SHALL hold GAP1 for exactly gap cycles with c1, c2 and i low; gap=0 SHALL skip GAP1 so that IND directly follows FIRST.
REQ-020 SHALL hold IND for exactly 1 cycle with i=1.
REQ-021 SHALL treat GAP2 identically to GAP1, using the same latched gap value.
REQ-022 SHALL hold SECOND for exactly 1 cycle, driving the condition not driven in FIRST.
REQ-023 SHALL, in WAIT, go to DONE if ca_in==2'b11 is sampled at an edge; otherwise it SHALL go to ERR once TIMEOUT WAIT cycles have elapsed without a match, with a match on the final cycle taking priority over timeout.
REQ-024 SHALL hold DONE for 1 cycle with done=1, then return to IDLE.
REQ-025 SHALL, given order=0 and gap=g with start sampled at edge 0, drive c1 in cycle 1, i in cycle 2+g, c2 in cycle 3+2g, and enter WAIT at cycle 4+2g.
REQ-026 SHALL use a single 8-bit down-counter for both gap and timeout, loaded on entry to GAP1, GAP2 and WAIT, with no wrap-around.
REQ-027 SHALL return to IDLE on the next edge when abort=1 in any busy state, with abort taking priority over start and ca_in; abort SHALL be ignored in IDLE, ERR and DONE.
REQ-028 SHALL never assert c1, c2 or i in the same cycle as one another.
REQ-029 SHALL ignore start while busy=1, with no relatch of order or gap.

Reset
REQ-030 SHALL, while reset=1, hold the state at IDLE, clear the counter and the latched order and gap to 0, and force c1, c2, i, busy, done and error to 0, independent of clk.
REQ-031 SHALL, on a reset asserted mid-sequence, drop all outputs immediately, and SHALL accept no start until the first rising edge after reset deasserts.

Verification
REQ-032 SHALL cover: order=0, gap=0, start at edge 0, ca_in=11 during WAIT -> c1 in cycle 1, i in cycle 2, c2 in cycle 3, done in cycle 5, then IDLE.
REQ-033 SHALL cover: order=1, gap=3 -> c2 in cycle 1, i in cycle 5, c1 in cycle 9, busy high in cycles 1..9 and throughout WAIT.
REQ-034 SHALL cover: ca_in held at 00 with TIMEOUT=15 -> error=1 after 15 WAIT cycles and held; a subsequent start clears error and begins FIRST in the next cycle.
REQ-035 SHALL cover: abort asserted during GAP1 with start also high -> IDLE next cycle, all outputs 0, and no restart.
REQ-036 SHALL cover: reset pulsed asynchronously during IND -> i and busy drop without a clock edge, and the sequence does not resume after release.
REQ-037 SHALL cover: start re-asserted during WAIT with different order and gap values -> ignored, and the original sequence completes unchanged.

Source files
------------

// File: rtl/fsm_seq_driver.sv
// Sequence driver for an interlock FSM: emits first-condition, enable and
// second-condition pulses with programmable gaps, then waits for a status code.
module fsm_seq_driver #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       order,
  input  logic [3:0] gap,
  input  logic       abort,
  input  logic [1:0] ca_in,
  output logic       c1,
  output logic       c2,
  output logic       i,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FIRST,
    S_GAP1,
    S_IND,
    S_GAP2,
    S_SECOND,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_order;
  logic [3:0] r_gap;
  logic       w_latch;
  logic       w_cnt_last;
  logic       w_gap_zero;

  assign w_cnt_last = (r_cnt <= 8'd1);
  assign w_gap_zero = (r_gap == 4'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shared gap/timeout down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= 8'd0;
    else       r_cnt <= w_cnt_nxt;
  end

  // Capture order and gap when a sequence is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_order <= 1'b0;
      r_gap   <= 4'd0;
    end else if (w_latch) begin
      r_order <= order;
      r_gap   <= gap;
    end
  end

  // Next-state and counter logic; abort outranks everything while running
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE, S_ERR: begin
        if (start) begin
          w_state_nxt = S_FIRST;
          w_latch     = 1'b1;
        end
      end
      S_FIRST: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_gap_zero) begin
          w_state_nxt = S_IND;
        end else begin
          w_state_nxt = S_GAP1;
          w_cnt_nxt   = {4'd0, r_gap};
        end
      end
      S_GAP1: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_cnt_last) w_state_nxt = S_IND;
      end
      S_IND: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_gap_zero) begin
          w_state_nxt = S_SECOND;
        end else begin
          w_state_nxt = S_GAP2;
          w_cnt_nxt   = {4'd0, r_gap};
        end
      end
      S_GAP2: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_cnt_last) w_state_nxt = S_SECOND;
      end
      S_SECOND: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LP_TIMEOUT;
        end
      end
      S_WAIT: begin
        if (abort)                 w_state_nxt = S_IDLE;
        else if (ca_in == 2'b11)   w_state_nxt = S_DONE;
        else if (w_cnt_last)       w_state_nxt = S_ERR;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state
  always_comb begin
    c1    = 1'b0;
    c2    = 1'b0;
    i     = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    error = 1'b0;
    unique case (r_state)
      S_IDLE:   busy = 1'b0;
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      S_FIRST: begin
        c1 = ~r_order;
        c2 = r_order;
      end
      S_SECOND: begin
        c1 = r_order;
        c2 = ~r_order;
      end
      S_IND:    i    = 1'b1;
      S_DONE:   done = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Self-checking bench for fsm_seq_driver: directed vector table, hand-written
// corner sequences, and random stimulus against a schedule-based model.
module tb_fsm_seq_driver;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       order = 1'b0;
  logic [3:0] gap = 4'd0;
  logic       abort = 1'b0;
  logic [1:0] ca_in = 2'd0;
  logic       c1, c2, i, busy, done, error;

  int n_chk = 0;
  int n_fail = 0;

  fsm_seq_driver #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .order (order),
    .gap   (gap),
    .abort (abort),
    .ca_in (ca_in),
    .c1    (c1),
    .c2    (c2),
    .i     (i),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  // expected vector layout: {c1, c2, i, busy, done, error}
  typedef struct {
    logic       st;
    logic       od;
    logic [3:0] gp;
    logic       ab;
    logic [1:0] ca;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic st, input logic od,
                              input logic [3:0] gp, input logic ab,
                              input logic [1:0] ca, input logic [5:0] exp);
    vec_t v;
    v.st = st; v.od = od; v.gp = gp; v.ab = ab; v.ca = ca; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic st, input logic od, input logic [3:0] gp,
                       input logic ab, input logic [1:0] ca);
    start = st; order = od; gap = gp; abort = ab; ca_in = ca;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [5:0] exp);
    logic [5:0] act;
    act = {c1, c2, i, busy, done, error};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got c1c2i_busy_done_err=%b expected %b at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: a running sequence is a timeline indexed by t.
  // t=0 first pulse, t=g+1 enable pulse, t=2g+2 second pulse,
  // t>=2g+3 waiting for status.
  int m_mode;
  int m_t;
  int m_o;
  int m_g;

  task automatic m_step(input logic st, input logic od, input logic [3:0] gp,
                        input logic ab, input logic [1:0] ca);
    int ws;
    case (m_mode)
      0, 3: if (st) begin
        m_mode = 1; m_t = 0; m_o = int'(od); m_g = int'(gp);
      end
      1: begin
        ws = 2 * m_g + 3;
        if (ab) m_mode = 0;
        else if (m_t >= ws) begin
          if (ca == 2'b11) m_mode = 2;
          else if (m_t - ws + 1 >= TO) m_mode = 3;
          else m_t++;
        end else m_t++;
      end
      default: m_mode = 0;
    endcase
  endtask

  function automatic logic [5:0] m_exp();
    logic [5:0] e;
    e = 6'd0;
    case (m_mode)
      1: begin
        e[2] = 1'b1;
        if (m_t == 0) begin
          e[5] = (m_o == 0); e[4] = (m_o == 1);
        end
        if (m_t == m_g + 1) e[3] = 1'b1;
        if (m_t == 2 * m_g + 2) begin
          e[5] = (m_o == 1); e[4] = (m_o == 0);
        end
      end
      2: e = 6'b000110;
      3: e = 6'b000001;
      default: e = 6'd0;
    endcase
    return e;
  endfunction

  initial begin
    logic       rs, ro, rab;
    logic [3:0] rg;
    logic [1:0] rca;

    // reset state, with start held high to show it is ignored
    start = 1'b1;
    #2 chk("reset_async", 6'd0);
    tick();
    tick();
    chk("reset_held", 6'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_after_reset", 6'd0);

    // order=0 gap=0 completes
    add(1, 0, 0, 0, 0, 6'b100100);
    add(0, 0, 0, 0, 0, 6'b001100);
    add(0, 0, 0, 0, 0, 6'b010100);
    add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 3, 6'b000110);
    add(0, 0, 0, 0, 0, 6'b000000);
    // order=1 gap=3, start re-asserted in WAIT is ignored
    add(1, 1, 3, 0, 0, 6'b010100);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 0, 6'b001100);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 0, 6'b100100);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 3, 6'b000110);
    add(0, 0, 0, 0, 0, 6'b000000);
    // abort in GAP1 with start high
    add(1, 0, 2, 0, 0, 6'b100100);
    add(0, 0, 2, 0, 0, 6'b000100);
    add(1, 0, 2, 1, 0, 6'b000000);
    add(0, 0, 2, 0, 0, 6'b000000);
    add(0, 0, 0, 1, 0, 6'b000000);
    // order=1 gap=1, abort beats ca_in match in WAIT
    add(1, 1, 1, 0, 0, 6'b010100);
    add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 0, 6'b001100);
    add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 0, 6'b100100);
    add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 1, 3, 6'b000000);
    // abort and start ignored in DONE
    add(1, 0, 0, 0, 0, 6'b100100);
    add(0, 0, 0, 0, 0, 6'b001100);
    add(0, 0, 0, 0, 0, 6'b010100);
    add(0, 0, 0, 0, 0, 6'b000100);
    add(0, 0, 0, 0, 3, 6'b000110);
    add(1, 0, 0, 1, 0, 6'b000000);
    add(0, 0, 0, 0, 0, 6'b000000);

    foreach (tbl[k]) begin
      drive(tbl[k].st, tbl[k].od, tbl[k].gp, tbl[k].ab, tbl[k].ca);
      tick();
      chk($sformatf("vec%0d", k), tbl[k].exp);
    end

    // timeout into ERR, held, then restart from ERR
    drive(1, 0, 0, 0, 0);
    tick();
    chk("to_first", 6'b100100);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    for (int k = 0; k < TO; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), 6'b000100);
    end
    tick();
    chk("to_error", 6'b000001);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_error_held", 6'b000001);
    end
    drive(1, 1, 0, 0, 0);
    tick();
    chk("err_restart", 6'b010100);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    drive(0, 0, 0, 0, 3);
    tick();
    chk("err_restart_done", 6'b000110);
    drive(0, 0, 0, 0, 0);
    tick();

    // match on the last WAIT cycle wins over timeout
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    for (int k = 0; k < TO - 1; k++) tick();
    chk("last_wait", 6'b000100);
    drive(0, 0, 0, 0, 3);
    tick();
    chk("last_wait_match", 6'b000110);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("last_wait_idle", 6'd0);

    // asynchronous reset during IND
    drive(1, 0, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("ind_before_rst", 6'b001100);
    #2 reset = 1'b1;
    #1 chk("ind_async_rst", 6'd0);
    start = 1'b1;
    tick();
    tick();
    chk("rst_start_ignored", 6'd0);
    reset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_resume", 6'd0);
    end
    // start accepted on the first edge after release
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1, 0, 0, 0, 0);
    tick();
    chk("start_after_release", 6'b100100);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("abort_first", 6'd0);
    drive(0, 0, 0, 0, 0);
    tick();

    // random stimulus against the model
    m_mode = 0; m_t = 0; m_o = 0; m_g = 0;
    for (int n = 0; n < 4000; n++) begin
      rs  = ($urandom % 4) == 0;
      ro  = 1'($urandom % 2);
      rg  = (($urandom % 3) == 0) ? 4'($urandom % 16) : 4'($urandom % 3);
      rab = ($urandom % 50) == 0;
      rca = (($urandom % 6) == 0) ? 2'b11 : 2'($urandom % 3);
      drive(rs, ro, rg, rab, rca);
      @(posedge clk);
      m_step(rs, ro, rg, rab, rca);
      #1;
      chk("rand", m_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
